exception_sequencer: RTL and testbench
======================================

// Module: exception_sequencer
// PURPOSE
//  Parametrised exception/trap sequencer for the multicycle MIPS datapath. The main controller raises a cause line; this
//  block saves EPC, records the cause, fetches the handler address from the vector table in memory, and loads PC.
//  It replaces the hard-wired overflow/invalid-opcode exception states in the main FSM and supports N causes,
//  configurable memory latency, and byte or word handler entries.
// PARAMETERS
//  DATA_W        32            datapath / address width
//  N_CAUSE       3             number of cause lines (bit0 = invalid opcode, bit1 = overflow, bit2 = div-by-zero)
//  VEC_BASE      32'h000000FD  byte address of vector entry for cause 0; cause i lives at VEC_BASE+i
//  MEM_LAT       1             memory read wait cycles (>=0)
//  HANDLER_BYTES 1             1: handler = zero-extended mem_rdata[7:0]; 4: handler = full mem_rdata word
// PORTS
//  clk        in   1                       clock, rising edge
//  reset      in   1                       asynchronous, active-high
//  cause_req  in   N_CAUSE                 level-sensitive exception requests from controller
//  pc_in      in   DATA_W                  current PC (already incremented past faulting instruction)
//  mem_rdata  in   DATA_W                  memory read data
//  busy       out  1                       high in every state except IDLE
//  epc_write  out  1                       EPC load strobe
//  epc_value  out  DATA_W                  value for EPC
//  cause_write out 1                       cause register load strobe
//  cause_id   out  clog2(N_CAUSE) (min 1)  encoded cause index
//  mem_read   out  1                       memory read request
//  mem_addr   out  DATA_W                  vector-table address
//  pc_write   out  1                       PC load strobe
//  pc_value   out  DATA_W                  handler address for PC
//  done       out  1                       1-cycle completion pulse
// BEHAVIOUR
//  Reset: state=IDLE; every output, latched index, handler register and wait counter = 0; async, effective immediately,
//    including mid-sequence (no partial PC write follows).
//  States (Moore outputs decoded from state and registers):
//   IDLE    : all strobes 0. On edge with |cause_req: latch idx = lowest set bit (bit0 highest priority) -> CAPTURE.
//             Non-winning simultaneous requests are dropped; the controller must re-raise them.
//   CAPTURE : 1 cycle. epc_write=1, epc_value=pc_in-4 (mod 2^DATA_W), cause_write=1, cause_id=idx -> READ.
//   READ    : MEM_LAT+1 cycles. mem_read=1, mem_addr=VEC_BASE+idx (mod 2^DATA_W); wait counter counts 0..MEM_LAT.
//             At the edge leaving READ, handler <= HANDLER_BYTES==1 ? {0,mem_rdata[7:0]} : mem_rdata -> JUMP.
//   JUMP    : 1 cycle. pc_write=1, pc_value=handler, done=1 -> IDLE.
//  Latency: request sampled at edge E0; busy for MEM_LAT+3 cycles; done high during cycle [E0+MEM_LAT+2, E0+MEM_LAT+3).
//  cause_req is ignored while busy. A level still high in IDLE after done starts a new sequence at the next edge.
//  mem_addr, epc_value, pc_value = 0 whenever their strobe is 0. cause_id holds its last latched value.
//  N_CAUSE=1: cause_id is 1 bit and always 0. Illegal parameter values (HANDLER_BYTES not in {1,4}) fail elaboration.
// TESTING
//  1 Defaults, cause_req=3'b010, pc_in=32'h14, mem[0xFE]=32'hA7 -> cycle1: epc_write, epc=0x10, cause_id=1;
//    cycles2-3: mem_read, addr=0xFE; cycle4: pc_write, pc_value=0xA7, done.
//  2 cause_req=3'b110 -> cause_id=1, mem_addr=0xFE; cause 2 dropped.
//  3 cause_req=3'b001 at E0, then 3'b100 raised mid-READ -> ignored; 3'b100 held -> second sequence starts the edge
//    after done, cause_id=2, addr=0xFF.
//  4 pc_in=0 -> epc_value=32'hFFFFFFFC; HANDLER_BYTES=4, mem_rdata=32'h12345678 -> pc_value=32'h12345678.
//  5 MEM_LAT=3 -> mem_read high for 4 cycles, done in cycle 6, busy for 6 cycles.
//  6 Assert reset during READ -> outputs 0 in the same cycle, no pc_write/done; the next request runs the full sequence.

Source files
------------

// File: rtl/exception_sequencer.sv
// Exception/trap sequencer for the multicycle MIPS datapath.
// On a cause request it saves EPC (pc_in-4), records the cause index, reads the
// handler address from the vector table (VEC_BASE+idx) and loads it into PC.
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   cause_req             level-sensitive requests, bit0 highest priority
//   pc_in, mem_rdata      current PC and memory read data
//   busy                  high whenever not idle
//   epc_write/epc_value   EPC load strobe and value
//   cause_write/cause_id  cause register strobe and encoded index (held)
//   mem_read/mem_addr     vector-table read request and address
//   pc_write/pc_value     PC load strobe and handler address
//   done                  one-cycle completion pulse
module exception_sequencer #(
  parameter int unsigned           DATA_W        = 32,
  parameter int unsigned           N_CAUSE       = 3,
  parameter logic [DATA_W-1:0]     VEC_BASE      = 'h0000_00FD,
  parameter int unsigned           MEM_LAT       = 1,
  parameter int unsigned           HANDLER_BYTES = 1,
  localparam int unsigned          IDX_W         = (N_CAUSE > 1) ? $clog2(N_CAUSE) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_CAUSE-1:0]  cause_req,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                epc_write,
  output logic [DATA_W-1:0]   epc_value,
  output logic                cause_write,
  output logic [IDX_W-1:0]    cause_id,
  output logic                mem_read,
  output logic [DATA_W-1:0]   mem_addr,
  output logic                pc_write,
  output logic [DATA_W-1:0]   pc_value,
  output logic                done
);

  localparam int unsigned CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  // Only byte or word vector entries are meaningful.
  if (!(HANDLER_BYTES == 1 || HANDLER_BYTES == 4)) begin : g_bad_handler_bytes
    $error("exception_sequencer: HANDLER_BYTES must be 1 or 4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    READ    = 2'd2,
    JUMP    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   handler_q, handler_d;
  logic [IDX_W-1:0]    pick;

  logic                busy_q, busy_d;
  logic                epc_write_q, epc_write_d;
  logic [DATA_W-1:0]   epc_value_q, epc_value_d;
  logic                cause_write_q, cause_write_d;
  logic                mem_read_q, mem_read_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic                pc_write_q, pc_write_d;
  logic [DATA_W-1:0]   pc_value_q, pc_value_d;
  logic                done_q, done_d;

  // Lowest set request bit wins; the downward loop lets the lowest index overwrite.
  always_comb begin
    pick = '0;
    for (int i = int'(N_CAUSE) - 1; i >= 0; i--) begin
      if (cause_req[i]) pick = IDX_W'(i);
    end
  end

  // Next state plus output decode of the next state, so registered outputs
  // line up with the state they belong to.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    handler_d     = handler_q;
    busy_d        = 1'b0;
    epc_write_d   = 1'b0;
    epc_value_d   = '0;
    cause_write_d = 1'b0;
    mem_read_d    = 1'b0;
    mem_addr_d    = '0;
    pc_write_d    = 1'b0;
    pc_value_d    = '0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (|cause_req) begin
          idx_d   = pick;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        if (cnt_q == CNT_W'(MEM_LAT)) begin
          handler_d = (HANDLER_BYTES == 1) ? DATA_W'(mem_rdata[7:0]) : mem_rdata;
          state_d   = JUMP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      JUMP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    case (state_d)
      CAPTURE: begin
        epc_write_d   = 1'b1;
        epc_value_d   = pc_in - DATA_W'(4);
        cause_write_d = 1'b1;
      end
      READ: begin
        mem_read_d = 1'b1;
        mem_addr_d = VEC_BASE + DATA_W'(idx_d);
      end
      JUMP: begin
        pc_write_d = 1'b1;
        pc_value_d = handler_d;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // State, latched index, wait counter, handler and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      handler_q     <= '0;
      busy_q        <= 1'b0;
      epc_write_q   <= 1'b0;
      epc_value_q   <= '0;
      cause_write_q <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_addr_q    <= '0;
      pc_write_q    <= 1'b0;
      pc_value_q    <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      handler_q     <= handler_d;
      busy_q        <= busy_d;
      epc_write_q   <= epc_write_d;
      epc_value_q   <= epc_value_d;
      cause_write_q <= cause_write_d;
      mem_read_q    <= mem_read_d;
      mem_addr_q    <= mem_addr_d;
      pc_write_q    <= pc_write_d;
      pc_value_q    <= pc_value_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign epc_write   = epc_write_q;
  assign epc_value   = epc_value_q;
  assign cause_write = cause_write_q;
  assign cause_id    = idx_q;
  assign mem_read    = mem_read_q;
  assign mem_addr    = mem_addr_q;
  assign pc_write    = pc_write_q;
  assign pc_value    = pc_value_q;
  assign done        = done_q;

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed bench: dut0 uses default parameters (byte handlers, MEM_LAT=1),
// dut1 uses MEM_LAT=3 with word handlers. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_exception_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // dut0 signals
  logic [2:0]  req0;
  logic [31:0] pc_in0, rdata0, epc0, addr0, pcv0;
  logic [1:0]  cid0;
  logic        busy0, epcw0, cw0, mrd0, pcw0, done0;
  // dut1 signals
  logic [2:0]  req1;
  logic [31:0] pc_in1, rdata1, epc1, addr1, pcv1;
  logic [1:0]  cid1;
  logic        busy1, epcw1, cw1, mrd1, pcw1, done1;

  // Vector table contents at 0xFD, 0xFE, 0xFF.
  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    case (a)
      32'h0000_00FD: return 32'h0000_0155;
      32'h0000_00FE: return 32'h0000_00A7;
      32'h0000_00FF: return 32'h1234_5678;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign rdata0 = mem_lookup(addr0);
  assign rdata1 = mem_lookup(addr1);

  exception_sequencer dut0 (
    .clk(clk), .reset(reset), .cause_req(req0), .pc_in(pc_in0), .mem_rdata(rdata0),
    .busy(busy0), .epc_write(epcw0), .epc_value(epc0), .cause_write(cw0), .cause_id(cid0),
    .mem_read(mrd0), .mem_addr(addr0), .pc_write(pcw0), .pc_value(pcv0), .done(done0)
  );

  exception_sequencer #(.MEM_LAT(3), .HANDLER_BYTES(4)) dut1 (
    .clk(clk), .reset(reset), .cause_req(req1), .pc_in(pc_in1), .mem_rdata(rdata1),
    .busy(busy1), .epc_write(epcw1), .epc_value(epc1), .cause_write(cw1), .cause_id(cid1),
    .mem_read(mrd1), .mem_addr(addr1), .pc_write(pcw1), .pc_value(pcv1), .done(done1)
  );

  // Flag order: {busy, epc_write, cause_write, mem_read, pc_write, done}
  localparam logic [5:0] F_IDLE = 6'b000000;
  localparam logic [5:0] F_CAP  = 6'b111000;
  localparam logic [5:0] F_RD   = 6'b100100;
  localparam logic [5:0] F_JMP  = 6'b100011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk0(input string tag, input logic [5:0] f, input logic [31:0] epc,
                      input logic [1:0] cid, input logic [31:0] addr, input logic [31:0] pcv);
    chk({tag, ".flags"}, 32'({busy0, epcw0, cw0, mrd0, pcw0, done0}), 32'(f));
    chk({tag, ".epc"},   epc0, epc);
    chk({tag, ".cid"},   32'(cid0), 32'(cid));
    chk({tag, ".addr"},  addr0, addr);
    chk({tag, ".pc"},    pcv0, pcv);
  endtask

  task automatic chk1(input string tag, input logic [5:0] f, input logic [31:0] epc,
                      input logic [1:0] cid, input logic [31:0] addr, input logic [31:0] pcv);
    chk({tag, ".flags"}, 32'({busy1, epcw1, cw1, mrd1, pcw1, done1}), 32'(f));
    chk({tag, ".epc"},   epc1, epc);
    chk({tag, ".cid"},   32'(cid1), 32'(cid));
    chk({tag, ".addr"},  addr1, addr);
    chk({tag, ".pc"},    pcv1, pcv);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; req0 = '0; req1 = '0; pc_in0 = '0; pc_in1 = '0;
    @(negedge clk);
    chk0("rst0", F_IDLE, 0, 0, 0, 0);
    chk1("rst1", F_IDLE, 0, 0, 0, 0);
    reset = 1'b0;
    tick();

    // 1: overflow cause, byte handler at 0xFE
    pc_in0 = 32'h14; req0 = 3'b010;
    tick(); chk0("t1.c1", F_CAP, 32'h10, 1, 0, 0);
    req0 = 3'b000;
    tick(); chk0("t1.c2", F_RD, 0, 1, 32'hFE, 0);
    tick(); chk0("t1.c3", F_RD, 0, 1, 32'hFE, 0);
    tick(); chk0("t1.c4", F_JMP, 0, 1, 0, 32'hA7);
    tick(); chk0("t1.c5", F_IDLE, 0, 1, 0, 0);

    // 2: simultaneous requests, lower index wins, higher one dropped
    pc_in0 = 32'h100; req0 = 3'b110;
    tick(); chk0("t2.c1", F_CAP, 32'hFC, 1, 0, 0);
    req0 = 3'b000;
    tick(); chk0("t2.c2", F_RD, 0, 1, 32'hFE, 0);
    tick(); chk0("t2.c3", F_RD, 0, 1, 32'hFE, 0);
    tick(); chk0("t2.c4", F_JMP, 0, 1, 0, 32'hA7);
    tick(); chk0("t2.c5", F_IDLE, 0, 1, 0, 0);
    tick(); chk0("t2.c6", F_IDLE, 0, 1, 0, 0);

    // 3: request raised while busy is ignored until idle, then served
    pc_in0 = 32'h20; req0 = 3'b001;
    tick(); chk0("t3.c1", F_CAP, 32'h1C, 0, 0, 0);
    req0 = 3'b100;
    tick(); chk0("t3.c2", F_RD, 0, 0, 32'hFD, 0);
    tick(); chk0("t3.c3", F_RD, 0, 0, 32'hFD, 0);
    tick(); chk0("t3.c4", F_JMP, 0, 0, 0, 32'h55);
    tick(); chk0("t3.c5", F_IDLE, 0, 0, 0, 0);
    tick(); chk0("t3.c6", F_CAP, 32'h1C, 2, 0, 0);
    req0 = 3'b000;
    tick(); chk0("t3.c7", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk0("t3.c8", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk0("t3.c9", F_JMP, 0, 2, 0, 32'h78);
    tick(); chk0("t3.c10", F_IDLE, 0, 2, 0, 0);

    // 4+5: EPC wrap, word handler, MEM_LAT=3
    pc_in1 = 32'h0; req1 = 3'b100;
    tick(); chk1("t4.c1", F_CAP, 32'hFFFF_FFFC, 2, 0, 0);
    req1 = 3'b000;
    tick(); chk1("t5.c2", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk1("t5.c3", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk1("t5.c4", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk1("t5.c5", F_RD, 0, 2, 32'hFF, 0);
    tick(); chk1("t4.c6", F_JMP, 0, 2, 0, 32'h1234_5678);
    tick(); chk1("t5.c7", F_IDLE, 0, 2, 0, 0);

    // 6: asynchronous reset in the middle of READ
    pc_in0 = 32'h40; req0 = 3'b010;
    tick(); chk0("t6.c1", F_CAP, 32'h3C, 1, 0, 0);
    req0 = 3'b000;
    tick(); chk0("t6.c2", F_RD, 0, 1, 32'hFE, 0);
    #2 reset = 1'b1;
    #1 chk0("t6.rst", F_IDLE, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    tick(); chk0("t6.p1", F_IDLE, 0, 0, 0, 0);
    tick(); chk0("t6.p2", F_IDLE, 0, 0, 0, 0);
    pc_in0 = 32'h8; req0 = 3'b001;
    tick(); chk0("t6.c1b", F_CAP, 32'h4, 0, 0, 0);
    req0 = 3'b000;
    tick(); chk0("t6.c2b", F_RD, 0, 0, 32'hFD, 0);
    tick(); chk0("t6.c3b", F_RD, 0, 0, 32'hFD, 0);
    tick(); chk0("t6.c4b", F_JMP, 0, 0, 0, 32'h55);
    tick(); chk0("t6.c5b", F_IDLE, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
